alu_rr_sched: RTL and testbench

- Round-robin scheduler that shares one combinational ALU datapath between two requesters.
- Each requester submits an opcode and two operands over a valid/ready handshake.
- The scheduler registers the operands and drives the shared ALU. It then captures result, zero flag and overflow flag, and returns them on a single tagged response channel with backpressure.
- Sits between the two issuing masters and the ALU instance. Also counts completed operations.

---
 rtl/alu_rr_sched_if.sv | 53 +++++
 rtl/alu_rr_sched.sv | 109 ++++++++++
 tb/tb_alu_rr_sched.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_sched_if.sv
// Bundle of request, ALU and response signals shared by the round-robin ALU scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface alu_rr_sched_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [3:0]            req0_op;
    logic [DATA_WIDTH-1:0] req0_a;
    logic [DATA_WIDTH-1:0] req0_b;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [3:0]            req1_op;
    logic [DATA_WIDTH-1:0] req1_a;
    logic [DATA_WIDTH-1:0] req1_b;

    logic [3:0]            alu_opcode;
    logic [DATA_WIDTH-1:0] alu_dina;
    logic [DATA_WIDTH-1:0] alu_dinb;
    logic [DATA_WIDTH-1:0] alu_doutr;
    logic                  alu_doutz;
    logic                  alu_flag_of;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_zero;
    logic                  rsp_of;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_opcode, alu_dina, alu_dinb,
        input  alu_doutr, alu_doutz, alu_flag_of,
        output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_of,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_opcode, alu_dina, alu_dinb,
        output alu_doutr, alu_doutz, alu_flag_of,
        input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_of,
        output rsp_ready
    );
endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational ALU between two requesters,
// returning tagged results on a single backpressured response channel.
module alu_rr_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_rr_sched_if.slave        bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  rr_ptr;
    logic                  grant0;
    logic                  grant1;
    logic [3:0]            alu_opcode_q;
    logic [DATA_WIDTH-1:0] alu_dina_q;
    logic [DATA_WIDTH-1:0] alu_dinb_q;
    logic                  rsp_id_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_zero_q;
    logic                  rsp_of_q;

    // A lone requester always wins; rr_ptr only breaks ties.
    always_comb begin
        grant1 = bus.req1_valid & (~bus.req0_valid | rr_ptr);
        grant0 = bus.req0_valid & ~grant1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant0 | grant1) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= 1'b0;
            alu_opcode_q <= '0;
            alu_dina_q   <= '0;
            alu_dinb_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_of_q     <= 1'b0;
            done_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant1) begin
                        alu_opcode_q <= bus.req1_op;
                        alu_dina_q   <= bus.req1_a;
                        alu_dinb_q   <= bus.req1_b;
                        rsp_id_q     <= 1'b1;
                    end else if (grant0) begin
                        alu_opcode_q <= bus.req0_op;
                        alu_dina_q   <= bus.req0_a;
                        alu_dinb_q   <= bus.req0_b;
                        rsp_id_q     <= 1'b0;
                    end
                end
                EXEC: begin
                    rsp_data_q <= bus.alu_doutr;
                    rsp_zero_q <= bus.alu_doutz;
                    rsp_of_q   <= bus.alu_flag_of;
                end
                RESP: begin
                    // The requester just served loses the next tie.
                    if (bus.rsp_ready) begin
                        rr_ptr   <= ~rsp_id_q;
                        done_cnt <= done_cnt + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = (state == IDLE) & grant0;
    assign bus.req1_ready = (state == IDLE) & grant1;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_dina   = alu_dina_q;
    assign bus.alu_dinb   = alu_dinb_q;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_of     = rsp_of_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched with a small behavioural ALU and a 4-bit
// completion counter so that wrap-around is reachable.
module tb_alu_rr_sched;

    localparam int DW = 8;
    localparam int CW = 4;

    localparam logic [3:0] ALUC_ADD = 4'h0;
    localparam logic [3:0] ALUC_SUB = 4'h1;
    localparam logic [3:0] ALUC_AND = 4'h2;
    localparam logic [3:0] ALUC_OR  = 4'h3;
    localparam logic [3:0] ALUC_XOR = 4'h4;

    typedef struct {
        logic          v0;
        logic          v1;
        logic [3:0]    op0;
        logic [DW-1:0] a0;
        logic [DW-1:0] b0;
        logic [3:0]    op1;
        logic [DW-1:0] a1;
        logic [DW-1:0] b1;
        logic          exp_id;
        logic [DW-1:0] exp_data;
        logic          exp_zero;
        logic          exp_of;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          busy;
    logic [CW-1:0] done_cnt;
    logic [CW-1:0] exp_cnt;
    int            checks;
    int            errors;
    vec_t          vecs [9];
    logic [DW:0]   alu_tmp;

    alu_rr_sched_if #(.DATA_WIDTH(DW)) bus ();

    alu_rr_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    // Reference ALU: flag_of is the carry out of ADD and the borrow of SUB.
    always_comb begin
        alu_tmp = '0;
        case (bus.alu_opcode)
            ALUC_ADD: alu_tmp = {1'b0, bus.alu_dina} + {1'b0, bus.alu_dinb};
            ALUC_SUB: alu_tmp = {1'b0, bus.alu_dina} - {1'b0, bus.alu_dinb};
            ALUC_AND: alu_tmp = {1'b0, bus.alu_dina & bus.alu_dinb};
            ALUC_OR:  alu_tmp = {1'b0, bus.alu_dina | bus.alu_dinb};
            ALUC_XOR: alu_tmp = {1'b0, bus.alu_dina ^ bus.alu_dinb};
            default:  alu_tmp = '0;
        endcase
        bus.alu_doutr   = alu_tmp[DW-1:0];
        bus.alu_doutz   = (alu_tmp[DW-1:0] == '0);
        bus.alu_flag_of = alu_tmp[DW];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        bus.req0_valid = 1'b0;
        bus.req0_op    = '0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = '0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        clearInputs();
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issues one vector from an idle negedge and follows it through to completion.
    task automatic applyStimulus(input vec_t v);
        int n;
        bus.req0_valid = v.v0;
        bus.req0_op    = v.op0;
        bus.req0_a     = v.a0;
        bus.req0_b     = v.b0;
        bus.req1_valid = v.v1;
        bus.req1_op    = v.op1;
        bus.req1_a     = v.a1;
        bus.req1_b     = v.b1;
        bus.rsp_ready  = 1'b1;
        #1;
        n = 0;
        while (!(bus.req0_ready || bus.req1_ready) && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("grant_wait", n, 0);
        if (n < 8) begin
            checkOutput("grant_idx", {bus.req1_ready, bus.req0_ready}, v.exp_id ? 2'b10 : 2'b01);
            @(negedge clk);
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            checkOutput("exec_busy", busy, 1);
            checkOutput("exec_rsp_valid", bus.rsp_valid, 0);
            @(negedge clk);
            checkOutput("rsp_valid", bus.rsp_valid, 1);
            checkOutput("rsp_id", bus.rsp_id, v.exp_id);
            checkOutput("rsp_data", bus.rsp_data, v.exp_data);
            checkOutput("rsp_zero", bus.rsp_zero, v.exp_zero);
            checkOutput("rsp_of", bus.rsp_of, v.exp_of);
            @(negedge clk);
            exp_cnt = exp_cnt + 1'b1;
            checkOutput("done_cnt", done_cnt, exp_cnt);
            checkOutput("idle_rsp_valid", bus.rsp_valid, 0);
            checkOutput("idle_busy", busy, 0);
        end else begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t w;
        checks = 0;
        errors = 0;
        exp_cnt = '0;
        rst_n = 1'b0;
        clearInputs();

        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, 1'b1, ALUC_ADD, 8'h01, 8'h01, ALUC_XOR, 8'hF0, 8'h0F,
                        i[0], (i[0] ? 8'hFF : 8'h02), 1'b0, 1'b0};
        end
        vecs[8] = '{1'b0, 1'b1, ALUC_AND, 8'h00, 8'h00, ALUC_ADD, 8'hFF, 8'h01,
                    1'b1, 8'h00, 1'b1, 1'b1};

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done_cnt", done_cnt, 0);
        checkOutput("rst_alu_opcode", bus.alu_opcode, 0);
        checkOutput("rst_alu_dina", bus.alu_dina, 0);
        checkOutput("rst_alu_dinb", bus.alu_dinb, 0);
        checkOutput("rst_rsp_id", bus.rsp_id, 0);
        checkOutput("rst_rsp_data", bus.rsp_data, 0);
        checkOutput("rst_rsp_zero", bus.rsp_zero, 0);
        checkOutput("rst_rsp_of", bus.rsp_of, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // req0 alone: ADD 5+3 with cycle-exact latency.
        bus.req0_valid = 1'b1;
        bus.req0_op    = ALUC_ADD;
        bus.req0_a     = 8'h05;
        bus.req0_b     = 8'h03;
        #1;
        checkOutput("t1_req0_ready", bus.req0_ready, 1);
        checkOutput("t1_req1_ready", bus.req1_ready, 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        checkOutput("t1_alu_opcode", bus.alu_opcode, ALUC_ADD);
        checkOutput("t1_alu_dina", bus.alu_dina, 8'h05);
        checkOutput("t1_alu_dinb", bus.alu_dinb, 8'h03);
        checkOutput("t1_exec_valid", bus.rsp_valid, 0);
        @(negedge clk);
        checkOutput("t1_rsp_valid", bus.rsp_valid, 1);
        checkOutput("t1_rsp_id", bus.rsp_id, 0);
        checkOutput("t1_rsp_data", bus.rsp_data, 8'h08);
        checkOutput("t1_rsp_zero", bus.rsp_zero, 0);
        checkOutput("t1_rsp_of", bus.rsp_of, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput("t1_done_cnt", done_cnt, 1);
        checkOutput("t1_rsp_valid_low", bus.rsp_valid, 0);

        // Fairness from reset, then a carry/zero case on req1.
        applyReset();
        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

        // Backpressure: SUB 33-33 held for 5 cycles while both requesters wait.
        bus.req0_valid = 1'b1;
        bus.req0_op    = ALUC_SUB;
        bus.req0_a     = 8'h33;
        bus.req0_b     = 8'h33;
        #1;
        checkOutput("t4_req0_ready", bus.req0_ready, 1);
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_op    = ALUC_ADD;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_hold_valid", bus.rsp_valid, 1);
            checkOutput("t4_hold_data", bus.rsp_data, 8'h00);
            checkOutput("t4_hold_zero", bus.rsp_zero, 1);
            checkOutput("t4_hold_of", bus.rsp_of, 0);
            checkOutput("t4_hold_id", bus.rsp_id, 0);
            checkOutput("t4_hold_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        checkOutput("t4_done_cnt", done_cnt, exp_cnt);
        checkOutput("t4_rsp_valid_low", bus.rsp_valid, 0);

        // Asynchronous reset while a response is pending.
        bus.req0_valid = 1'b1;
        bus.req0_op    = ALUC_ADD;
        bus.req0_a     = 8'h10;
        bus.req0_b     = 8'h20;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        checkOutput("t5_pending_data", bus.rsp_data, 8'h30);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", bus.rsp_valid, 0);
        checkOutput("t5_rst_data", bus.rsp_data, 0);
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_cnt", done_cnt, 0);
        checkOutput("t5_rst_dina", bus.alu_dina, 0);
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t5_no_stale_rsp", bus.rsp_valid, 0);
        w = '{1'b0, 1'b0, ALUC_ADD, 8'h00, 8'h00, ALUC_ADD, 8'h02, 8'h03, 1'b1, 8'h05, 1'b0, 1'b0};
        w.v1 = 1'b1;
        applyStimulus(w);

        // Counter wrap on the 4-bit build.
        applyReset();
        w = '{1'b1, 1'b0, ALUC_AND, 8'hFF, 8'h0F, ALUC_ADD, 8'h00, 8'h00, 1'b0, 8'h0F, 1'b0, 1'b0};
        for (int i = 0; i < 16; i++) applyStimulus(w);
        checkOutput("t6_cnt_wrap", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
